regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-read-port register file for the pipelined MIPS core. Adds over the
//  single-cycle file: synchronous reset with a hardware clear sequence, write-to-read bypass,
//  and a per-register busy scoreboard. Decode uses the scoreboard for RAW hazard detection.
//  Sits between decode (read/issue) and writeback (write).
// PARAMETERS
//  DATA_W    32  register width
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W registers
//  NUM_RD    2   number of independent read ports
//  ZERO_REG  1   1: reg 0 reads 0, ignores writes, never busy; 0: reg 0 is ordinary
//  BYPASS    1   1: same-cycle write data forwarded to reads; 0: reads return pre-write value
// PORTS
//  Clk     in   1               clock, all state on rising edge
//  Rst     in   1               synchronous, active-high reset
//  RdAddr  in   NUM_RD*ADDR_W   read addresses, port i = bits [i*ADDR_W +: ADDR_W]
//  RdData  out  NUM_RD*DATA_W   read data, port i = bits [i*DATA_W +: DATA_W]
//  RdBusy  out  NUM_RD          1 = register on port i has a pending producer
//  WrAddr  in   ADDR_W          writeback address
//  DataIn  in   DATA_W          writeback data
//  RegWr   in   1               writeback enable, active high
//  IssAddr in   ADDR_W          destination of the instruction being issued
//  IssVld  in   1               issue strobe; marks IssAddr busy
//  Ready   out  1               1 = clear sequence done, file usable
// BEHAVIOUR
//  - FSM states: INIT and READY.
//  - Reset: Rst high at an edge gives state=INIT, clr_cnt=0, all busy=0, Ready=0.
//    Rst wins over every other input. Rst asserted in READY or mid-INIT restarts the clear.
//  - INIT sequence:
//    - Each edge with Rst=0 writes 0 to regs[clr_cnt] and increments clr_cnt.
//    - The edge that clears DEPTH-1 moves to READY. Ready=1 exactly DEPTH edges after the
//      last Rst edge (32 for defaults).
//    - RegWr and IssVld are ignored in INIT. RdData=0 and RdBusy=0 while Ready=0.
//  - Write enable: wr_ok = Ready & RegWr & ~(ZERO_REG & WrAddr==0).
//    - On the edge: regs[WrAddr] <= DataIn and busy[WrAddr] <= 0.
//  - Issue enable: iss_ok = Ready & IssVld & ~(ZERO_REG & IssAddr==0).
//    - On the edge: busy[IssAddr] <= 1.
//    - iss_ok and wr_ok to the same address on the same edge: busy ends 1 (new producer wins).
//    - Data is still written.
//  - Reads are combinational, zero latency, and fully independent per port.
//    - Duplicate addresses across ports are legal.
//    - RdData[i] = 0 if ZERO_REG & RdAddr[i]==0.
//    - Else, if BYPASS & wr_ok & WrAddr==RdAddr[i]: DataIn.
//    - Else: regs[RdAddr[i]].
//  - Busy flags:
//    - RdBusy[i] = busy[RdAddr[i]] & ~(BYPASS & wr_ok & WrAddr==RdAddr[i]).
//    - The producer arriving this cycle is not a hazard.
//    - With BYPASS=0, RdBusy stays 1 in the writeback cycle and clears the cycle after.
//  - Issue does not affect RdBusy until the edge after IssVld (no issue-to-read forwarding).
//  - Writing a register that is not busy is legal: data is stored, busy stays 0.
//  - Address wrap: none. All addresses are in range by width.
// STRUCTURE
//  - Package regfile_pkg holds: default DATA_W/ADDR_W/NUM_RD constants, the state encoding
//    ST_INIT=1'b0 / ST_READY=1'b1, and the DEPTH function.
//  - One sub-module: regfile_scoreboard (DEPTH-bit busy vector with set/clear ports, set-wins
//    priority, NUM_RD lookup outputs).
//  - Storage array, clear FSM and bypass muxes stay in regfile_sb. Read muxes are generated
//    per port.
// TESTING
//  1. Rst high 1 cycle, then low.
//     -> Ready=0 for 32 edges, 1 after edge 32. Every register then reads 0.
//  2. Ready. Write reg 5 = 0xDEADBEEF with port0 addr 5, BYPASS=1.
//     -> RdData0=0xDEADBEEF in the write cycle. Still 0xDEADBEEF next cycle.
//  3. Write reg 0 = 0x12345678 and issue reg 0.
//     -> Reg 0 reads 0 on both ports. RdBusy=0 forever.
//  4. Issue reg 7.
//     -> Next cycle RdBusy=1 on a port reading 7.
//     Then write reg 7 = 0xA5A5A5A5.
//     -> RdBusy=0 and data valid in the same cycle (BYPASS=1). With BYPASS=0: RdBusy=1,
//        old data, then 0xA5A5A5A5 with RdBusy=0 next cycle.
//  5. Busy reg 9. Same-edge issue 9 and write 9 = 0x1.
//     -> After the edge: reg 9 reads 0x1 and RdBusy=1.
//  6. Rst pulse at clear count 10 with busy reg 3 set.
//     -> Ready=0, busy cleared. Ready returns 32 edges after the pulse. Writes during INIT
//        are discarded (reg reads 0).

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, clear-FSM state encoding and sizing helper for the
// scoreboarded register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector: issue sets, writeback clears, set wins on a tie.
// Provides one combinational busy lookup per read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int DEPTH  = depth(ADDR_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        busy_out
);

  logic [DEPTH-1:0] busy;

  // Set is applied after clear so a new producer overrides a retiring one.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_lookup
    assign busy_out[i] = busy[rd_addr[i*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with hardware clear after reset,
// write-to-read bypass and a busy scoreboard for RAW hazard detection.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  output logic [NUM_RD-1:0]        RdBusy,
  input  logic [ADDR_W-1:0]        WrAddr,
  input  logic [DATA_W-1:0]        DataIn,
  input  logic                     RegWr,
  input  logic [ADDR_W-1:0]        IssAddr,
  input  logic                     IssVld,
  output logic                     Ready,
  output state_t                   state_dbg
);

  localparam int DEPTH = depth(ADDR_W);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nx;
  logic                clr_we;
  logic                wr_ok;
  logic                iss_ok;
  logic [NUM_RD-1:0]   sb_busy;
  logic [DATA_W-1:0]   regs [DEPTH];

  // Clear FSM: INIT walks every register once, then parks in READY.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    clr_we     = 1'b0;
    case (state)
      ST_INIT: begin
        clr_we     = 1'b1;
        clr_cnt_nx = clr_cnt + 1'b1;
        if (clr_cnt == {ADDR_W{1'b1}}) state_nx = ST_READY;
      end
      ST_READY: begin
        state_nx = ST_READY;
      end
      default: begin
        state_nx = ST_INIT;
      end
    endcase
  end

  assign Ready     = (state == ST_READY);
  assign state_dbg = state;

  assign wr_ok  = Ready && RegWr  && !((ZERO_REG != 0) && (WrAddr  == '0));
  assign iss_ok = Ready && IssVld && !((ZERO_REG != 0) && (IssAddr == '0));

  // The array has no reset of its own; the INIT walk zeroes it.
  // wr_ok requires READY, so the clear and writeback paths never collide.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (clr_we) begin
        regs[clr_cnt] <= '0;
      end else if (wr_ok) begin
        regs[WrAddr] <= DataIn;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .DEPTH  (DEPTH)
  ) u_scoreboard (
    .clk      (Clk),
    .rst      (Rst),
    .set_en   (iss_ok),
    .set_addr (IssAddr),
    .clr_en   (wr_ok),
    .clr_addr (WrAddr),
    .rd_addr  (RdAddr),
    .busy_out (sb_busy)
  );

  // A producer writing back this cycle is forwarded and is not a hazard.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic              zero;

    assign addr = RdAddr[i*ADDR_W +: ADDR_W];
    assign hit  = (BYPASS != 0) && wr_ok && (WrAddr == addr);
    assign zero = (ZERO_REG != 0) && (addr == '0);

    assign RdData[i*DATA_W +: DATA_W] = (!Ready || zero) ? '0 :
                                        hit              ? DataIn :
                                                           regs[addr];
    assign RdBusy[i] = Ready && !zero && sb_busy[i] && !hit;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing
// instance share stimulus; expected values are hand-derived constants.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [9:0]  RdAddr;
  logic [4:0]  WrAddr;
  logic [31:0] DataIn;
  logic        RegWr;
  logic [4:0]  IssAddr;
  logic        IssVld;

  logic [63:0] rd_data_b,  rd_data_n;
  logic [1:0]  rd_busy_b,  rd_busy_n;
  logic        ready_b,    ready_n;
  state_t      state_b,    state_n;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  regfile_sb #(.BYPASS(1)) dut (
    .Clk(Clk), .Rst(Rst), .RdAddr(RdAddr), .RdData(rd_data_b), .RdBusy(rd_busy_b),
    .WrAddr(WrAddr), .DataIn(DataIn), .RegWr(RegWr), .IssAddr(IssAddr),
    .IssVld(IssVld), .Ready(ready_b), .state_dbg(state_b)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .Clk(Clk), .Rst(Rst), .RdAddr(RdAddr), .RdData(rd_data_n), .RdBusy(rd_busy_n),
    .WrAddr(WrAddr), .DataIn(DataIn), .RegWr(RegWr), .IssAddr(IssAddr),
    .IssVld(IssVld), .Ready(ready_n), .state_dbg(state_n)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    RdAddr = {a1, a0};
  endtask

  // Counts the clear walk after a reset edge: Ready low for 31 edges, high on the 32nd.
  task automatic walk_init(input string tag);
    for (int n = 1; n <= 32; n++) begin
      tick();
      RegWr = 1'b0;
      IssVld = 1'b0;
      #1;
      chk($sformatf("%s_ready_b_e%0d", tag, n), {31'b0, ready_b}, (n == 32) ? 32'd1 : 32'd0);
      chk($sformatf("%s_ready_n_e%0d", tag, n), {31'b0, ready_n}, (n == 32) ? 32'd1 : 32'd0);
      chk($sformatf("%s_state_e%0d", tag, n), {31'b0, state_b}, (n == 32) ? 32'd1 : 32'd0);
      if (n < 32) begin
        // Writeback/issue strobes during INIT must be discarded.
        RegWr = 1'b1; WrAddr = 5'd5; DataIn = 32'h5555_5555;
        IssVld = 1'b1; IssAddr = 5'd3;
        chk($sformatf("%s_init_data_e%0d", tag, n), rd_data_b[31:0], 32'h0);
        chk($sformatf("%s_init_busy_e%0d", tag, n), {30'b0, rd_busy_b}, 32'h0);
      end
    end
  endtask

  initial begin
    Rst = 1'b1; RdAddr = '0; WrAddr = '0; DataIn = '0; RegWr = 1'b0;
    IssAddr = '0; IssVld = 1'b0;

    // 1. Reset, clear walk, all registers zero
    tick();
    chk("rst_ready", {31'b0, ready_b}, 32'd0);
    chk("rst_busy",  {30'b0, rd_busy_b}, 32'd0);
    Rst = 1'b0;
    walk_init("t1");
    for (int a = 0; a < 32; a++) begin
      set_rd(a[4:0], 5'(31 - a));
      #1;
      chk($sformatf("t1_zero_p0_r%0d", a), rd_data_b[31:0],  32'h0);
      chk($sformatf("t1_zero_p1_r%0d", a), rd_data_b[63:32], 32'h0);
      chk($sformatf("t1_nobusy_r%0d", a), {30'b0, rd_busy_b}, 32'h0);
    end

    // 2. Write reg 5 with bypass visible in the write cycle
    set_rd(5'd5, 5'd6);
    RegWr = 1'b1; WrAddr = 5'd5; DataIn = 32'hDEAD_BEEF;
    #1;
    chk("t2_bypass_b", rd_data_b[31:0], 32'hDEAD_BEEF);
    chk("t2_prewrite_n", rd_data_n[31:0], 32'h0);
    chk("t2_other_port", rd_data_b[63:32], 32'h0);
    tick();
    RegWr = 1'b0;
    #1;
    chk("t2_held_b", rd_data_b[31:0], 32'hDEAD_BEEF);
    chk("t2_held_n", rd_data_n[31:0], 32'hDEAD_BEEF);
    chk("t2_notbusy", {30'b0, rd_busy_b}, 32'h0);

    // 3. Reg 0 ignores writes and issues
    set_rd(5'd0, 5'd0);
    RegWr = 1'b1; WrAddr = 5'd0; DataIn = 32'h1234_5678;
    IssVld = 1'b1; IssAddr = 5'd0;
    #1;
    chk("t3_r0_p0_wcyc", rd_data_b[31:0],  32'h0);
    chk("t3_r0_p1_wcyc", rd_data_b[63:32], 32'h0);
    tick();
    RegWr = 1'b0; IssVld = 1'b0;
    #1;
    chk("t3_r0_p0", rd_data_b[31:0],  32'h0);
    chk("t3_r0_p1", rd_data_n[63:32], 32'h0);
    chk("t3_r0_busy_b", {30'b0, rd_busy_b}, 32'h0);
    chk("t3_r0_busy_n", {30'b0, rd_busy_n}, 32'h0);

    // 4. Issue reg 7, then write it back
    set_rd(5'd5, 5'd7);
    IssVld = 1'b1; IssAddr = 5'd7;
    #1;
    chk("t4_no_iss_fwd", {30'b0, rd_busy_b}, 32'h0);
    tick();
    IssVld = 1'b0;
    #1;
    chk("t4_busy_b", {30'b0, rd_busy_b}, 32'h2);
    chk("t4_busy_n", {30'b0, rd_busy_n}, 32'h2);
    RegWr = 1'b1; WrAddr = 5'd7; DataIn = 32'hA5A5_A5A5;
    #1;
    chk("t4_wb_busy_b", {30'b0, rd_busy_b}, 32'h0);
    chk("t4_wb_data_b", rd_data_b[63:32], 32'hA5A5_A5A5);
    chk("t4_wb_busy_n", {30'b0, rd_busy_n}, 32'h2);
    chk("t4_wb_data_n", rd_data_n[63:32], 32'h0);
    tick();
    RegWr = 1'b0;
    #1;
    chk("t4_after_busy_n", {30'b0, rd_busy_n}, 32'h0);
    chk("t4_after_data_n", rd_data_n[63:32], 32'hA5A5_A5A5);
    chk("t4_after_data_b", rd_data_b[63:32], 32'hA5A5_A5A5);
    chk("t4_p0_r5", rd_data_b[31:0], 32'hDEAD_BEEF);

    // 5. Same-edge issue and writeback: data lands, busy stays set
    set_rd(5'd9, 5'd9);
    IssVld = 1'b1; IssAddr = 5'd9;
    tick();
    #1;
    chk("t5_busy_dup", {30'b0, rd_busy_b}, 32'h3);
    RegWr = 1'b1; WrAddr = 5'd9; DataIn = 32'h0000_0001;
    #1;
    chk("t5_wcyc_busy_b", {30'b0, rd_busy_b}, 32'h0);
    chk("t5_wcyc_busy_n", {30'b0, rd_busy_n}, 32'h3);
    tick();
    IssVld = 1'b0; RegWr = 1'b0;
    #1;
    chk("t5_data_b", rd_data_b[31:0], 32'h1);
    chk("t5_data_n", rd_data_n[63:32], 32'h1);
    chk("t5_busy_b", {30'b0, rd_busy_b}, 32'h3);
    chk("t5_busy_n", {30'b0, rd_busy_n}, 32'h3);

    // 6. Reset from READY, then again at clear count 10
    set_rd(5'd3, 5'd5);
    IssVld = 1'b1; IssAddr = 5'd3;
    tick();
    IssVld = 1'b0;
    #1;
    chk("t6_busy3", {30'b0, rd_busy_b}, 32'h1);
    Rst = 1'b1;
    tick();
    chk("t6_rst_ready", {31'b0, ready_b}, 32'd0);
    chk("t6_rst_state", {31'b0, state_b}, 32'd0);
    Rst = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    chk("t6_mid_ready", {31'b0, ready_b}, 32'd0);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    walk_init("t6");
    #1;
    chk("t6_r3_notbusy", {30'b0, rd_busy_b}, 32'h0);
    chk("t6_r3_zero", rd_data_b[31:0],  32'h0);
    chk("t6_r5_zero", rd_data_b[63:32], 32'h0);
    set_rd(5'd7, 5'd9);
    #1;
    chk("t6_r7_zero", rd_data_b[31:0],  32'h0);
    chk("t6_r9_zero", rd_data_n[63:32], 32'h0);
    chk("t6_r9_notbusy", {30'b0, rd_busy_n}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
